coin_sweep_controller: RTL and testbench

Sequencer and owner of all coin state in the maze. After reset it loads coin placements from the coin-locations ROM, then once per video frame sweeps every coin through a single shared Pac-Man/coin overlap comparator, clearing visibility of eaten coins, counting score and flagging level clear. The coin drawer reads per-coin position and visibility through a combinational read port.

---
 rtl/coin_pkg.sv | 34 +++
 rtl/coin_overlap_cmp.sv | 29 ++
 rtl/coin_sweep_controller.sv | 164 ++++++++++++++++
 tb/tb_coin_sweep_controller.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared types and constants for the coin sweep controller: FSM states,
// coin ROM word layout, sprite geometry and the per-slot coin record.
package coin_pkg;

    typedef enum logic [1:0] {
        S_LOAD_ADDR,
        S_LOAD_CAP,
        S_IDLE,
        S_SWEEP
    } state_t;

    localparam int unsigned ROM_W        = 38;
    localparam int unsigned X_W          = 10;
    localparam int unsigned Y_W          = 9;
    localparam int unsigned KIND_W       = 4;
    localparam int unsigned ROM_X_LSB    = 28;
    localparam int unsigned ROM_Y_LSB    = 19;
    localparam int unsigned ROM_KIND_LSB = 15;

    localparam int unsigned COIN_W   = 16;
    localparam int unsigned PAC_W    = 26;
    localparam int unsigned COIN_OFS = COIN_W - 1;
    localparam int unsigned PAC_OFS  = PAC_W - 1;

    // One bit wider than the screen coordinates so far-edge sums never wrap
    localparam int unsigned CMP_W = 11;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic           vis;
    } coin_t;

endpackage

// File: rtl/coin_overlap_cmp.sv
// Combinational box-overlap test between one 16x16 coin and the 26x26
// Pac-Man sprite, evaluated at 11 bits.
module coin_overlap_cmp
    import coin_pkg::*;
(
    input  logic [X_W-1:0] coin_x,
    input  logic [Y_W-1:0] coin_y,
    input  logic [X_W-1:0] pac_x,
    input  logic [Y_W-1:0] pac_y,
    output logic           hit
);

    logic [CMP_W-1:0] cx;
    logic [CMP_W-1:0] cy;
    logic [CMP_W-1:0] px;
    logic [CMP_W-1:0] py;

    always_comb begin
        cx  = CMP_W'(coin_x);
        cy  = CMP_W'(coin_y);
        px  = CMP_W'(pac_x);
        py  = CMP_W'(pac_y);
        hit = (cx + CMP_W'(COIN_OFS) >= px) &&
              (cx <= px + CMP_W'(PAC_OFS)) &&
              (cy + CMP_W'(COIN_OFS) >= py) &&
              (cy <= py + CMP_W'(PAC_OFS));
    end

endmodule

// File: rtl/coin_sweep_controller.sv
// Loads coin placements from ROM, then once per frame sweeps every coin
// through one shared overlap comparator, tracking visibility and score.
module coin_sweep_controller
    import coin_pkg::*;
#(
    parameter int unsigned N_COINS = 4,
    parameter int unsigned AW      = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               level_restart,
    input  logic [9:0]         pacman_left_x,
    input  logic [8:0]         pacman_top_y,
    output logic [AW-1:0]      rom_addr,
    input  logic [37:0]        rom_data,
    input  logic [AW-1:0]      draw_idx,
    output logic [9:0]         draw_x,
    output logic [8:0]         draw_y,
    output logic               draw_vis,
    output logic [N_COINS-1:0] coin_vis,
    output logic               eaten,
    output logic [7:0]         score,
    output logic               all_collected,
    output logic               busy
);

    localparam int unsigned   IW       = (N_COINS > 1) ? $clog2(N_COINS) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(N_COINS - 1);
    localparam logic [AW-1:0] NUM_IDX  = AW'(N_COINS);

    state_t         state;
    logic [AW-1:0]  idx;
    logic [IW-1:0]  sel;
    coin_t          slots [N_COINS];
    coin_t          cur;
    coin_t          rom_coin;
    logic           loaded;
    logic           pending;
    logic [X_W-1:0] pac_x_q;
    logic [Y_W-1:0] pac_y_q;
    logic           cmp_hit;
    logic           sweep_hit;
    logic           unused_rom_bits;

    assign sel      = idx[IW-1:0];
    assign rom_addr = idx;

    always_comb begin
        cur          = slots[sel];
        rom_coin.x   = rom_data[ROM_X_LSB +: X_W];
        rom_coin.y   = rom_data[ROM_Y_LSB +: Y_W];
        rom_coin.vis = |rom_data[ROM_KIND_LSB +: KIND_W];
    end

    assign unused_rom_bits = ^rom_data[ROM_KIND_LSB-1:0];

    coin_overlap_cmp u_cmp (
        .coin_x (cur.x),
        .coin_y (cur.y),
        .pac_x  (pac_x_q),
        .pac_y  (pac_y_q),
        .hit    (cmp_hit)
    );

    assign sweep_hit = (state == S_SWEEP) && cur.vis && cmp_hit;

    always_comb begin
        draw_x   = '0;
        draw_y   = '0;
        draw_vis = 1'b0;
        if (draw_idx < NUM_IDX) begin
            draw_x   = slots[draw_idx[IW-1:0]].x;
            draw_y   = slots[draw_idx[IW-1:0]].y;
            draw_vis = slots[draw_idx[IW-1:0]].vis;
        end
    end

    always_comb begin
        coin_vis = '0;
        for (int unsigned i = 0; i < N_COINS; i++) begin
            coin_vis[i] = slots[i].vis;
        end
    end

    assign all_collected = loaded & ~|coin_vis;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_LOAD_ADDR;
            idx     <= '0;
            loaded  <= 1'b0;
            pending <= 1'b0;
            eaten   <= 1'b0;
            score   <= '0;
            busy    <= 1'b1;
            pac_x_q <= '0;
            pac_y_q <= '0;
            for (int unsigned i = 0; i < N_COINS; i++) begin
                slots[i] <= '0;
            end
        end else begin
            eaten <= 1'b0;
            if (level_restart) begin
                // Slot contents are left in place; the reload overwrites them
                state   <= S_LOAD_ADDR;
                idx     <= '0;
                loaded  <= 1'b0;
                pending <= 1'b0;
                score   <= '0;
                busy    <= 1'b1;
            end else begin
                case (state)
                    S_LOAD_ADDR: begin
                        if (frame_start) pending <= 1'b1;
                        state <= S_LOAD_CAP;
                    end
                    S_LOAD_CAP: begin
                        if (frame_start) pending <= 1'b1;
                        slots[sel] <= rom_coin;
                        if (idx == LAST_IDX) begin
                            loaded <= 1'b1;
                            busy   <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            idx   <= idx + AW'(1);
                            state <= S_LOAD_ADDR;
                        end
                    end
                    S_IDLE: begin
                        if (frame_start || pending) begin
                            pending <= 1'b0;
                            idx     <= '0;
                            pac_x_q <= pacman_left_x;
                            pac_y_q <= pacman_top_y;
                            busy    <= 1'b1;
                            state   <= S_SWEEP;
                        end
                    end
                    S_SWEEP: begin
                        if (frame_start) pending <= 1'b1;
                        if (sweep_hit) begin
                            slots[sel].vis <= 1'b0;
                            eaten          <= 1'b1;
                            if (score != '1) score <= score + 8'd1;
                        end
                        if (idx == LAST_IDX) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end
                    default: begin
                        state <= S_LOAD_ADDR;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_coin_sweep_controller.sv
// Directed bench for coin_sweep_controller: a per-cycle behavioural model of
// load/sweep timing plus literal expectations for the headline scenarios.
module tb_coin_sweep_controller;

    localparam int N  = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_start;
    logic          level_restart;
    logic [9:0]    pacman_left_x;
    logic [8:0]    pacman_top_y;
    logic [AW-1:0] rom_addr;
    logic [37:0]   rom_data = '0;
    logic [AW-1:0] draw_idx;
    logic [9:0]    draw_x;
    logic [8:0]    draw_y;
    logic          draw_vis;
    logic [N-1:0]  coin_vis;
    logic          eaten;
    logic [7:0]    score;
    logic          all_collected;
    logic          busy;

    coin_sweep_controller #(.N_COINS(N), .AW(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .level_restart (level_restart),
        .pacman_left_x (pacman_left_x),
        .pacman_top_y  (pacman_top_y),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .draw_idx      (draw_idx),
        .draw_x        (draw_x),
        .draw_y        (draw_y),
        .draw_vis      (draw_vis),
        .coin_vis      (coin_vis),
        .eaten         (eaten),
        .score         (score),
        .all_collected (all_collected),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int rom_x [N];
    int rom_y [N];
    int rom_k [N];

    // Synchronous coin ROM, one-cycle latency; junk in the ignored low bits
    always @(posedge clk) begin
        if (int'(rom_addr) < N)
            rom_data <= {10'(rom_x[rom_addr]), 9'(rom_y[rom_addr]), 4'(rom_k[rom_addr]), 15'h5A5A};
        else
            rom_data <= '0;
    end

    int checks = 0;
    int errors = 0;
    int eaten_cnt = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: load phase counts 2N cycles, sweep visits slots in order
    int m_x [N];
    int m_y [N];
    bit m_vis [N];
    int m_score;
    bit m_loaded, m_pending, m_eaten;
    int load_cnt, sweep_slot, hold_px, hold_py;
    bit model_ok = 1'b0;

    function automatic bit overlap(input int cx, input int cy, input int px, input int py);
        // coin spans [c, c+15], Pac-Man spans [p, p+25] on each axis
        return (cx <= px + 25) && (px <= cx + 15) && (cy <= py + 25) && (py <= cy + 15);
    endfunction

    initial forever begin
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_x[i] = 0; m_y[i] = 0; m_vis[i] = 1'b0;
            end
            m_score = 0; m_loaded = 0; m_pending = 0; m_eaten = 0;
            load_cnt = 2 * N; sweep_slot = -1; hold_px = 0; hold_py = 0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            m_eaten = 1'b0;
            if (level_restart) begin
                load_cnt = 2 * N; sweep_slot = -1;
                m_score = 0; m_loaded = 0; m_pending = 0;
            end else if (load_cnt > 0) begin
                int c;
                c = 2 * N - load_cnt;
                if (c % 2 == 1) begin
                    m_x[c/2]   = rom_x[c/2];
                    m_y[c/2]   = rom_y[c/2];
                    m_vis[c/2] = (rom_k[c/2] != 0);
                end
                if (frame_start) m_pending = 1'b1;
                load_cnt--;
                if (load_cnt == 0) m_loaded = 1'b1;
            end else if (sweep_slot >= 0) begin
                if (frame_start) m_pending = 1'b1;
                if (m_vis[sweep_slot] && overlap(m_x[sweep_slot], m_y[sweep_slot], hold_px, hold_py)) begin
                    m_vis[sweep_slot] = 1'b0;
                    m_eaten = 1'b1;
                    if (m_score < 255) m_score++;
                end
                sweep_slot++;
                if (sweep_slot == N) sweep_slot = -1;
            end else if (frame_start || m_pending) begin
                m_pending = 1'b0;
                hold_px = int'(pacman_left_x);
                hold_py = int'(pacman_top_y);
                sweep_slot = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (eaten) eaten_cnt++;
        if (model_ok) begin
            int unsigned ev;
            int unsigned any_vis;
            int di;
            ev = 0;
            for (int i = 0; i < N; i++) if (m_vis[i]) ev += (1 << i);
            any_vis = (ev != 0) ? 1 : 0;
            check("coin_vis", coin_vis, ev);
            check("score", score, m_score);
            check("eaten", eaten, m_eaten);
            check("busy", busy, ((load_cnt > 0) || (sweep_slot >= 0)) ? 1 : 0);
            check("all_collected", all_collected, (m_loaded && any_vis == 0) ? 1 : 0);
            if (load_cnt > 0 && ((2 * N - load_cnt) % 2 == 0))
                check("rom_addr", rom_addr, (2 * N - load_cnt) / 2);
            di = int'(draw_idx);
            check("draw_x", draw_x, (di < N) ? m_x[di] : 0);
            check("draw_y", draw_y, (di < N) ? m_y[di] : 0);
            check("draw_vis", draw_vis, (di < N) ? int'(m_vis[di]) : 0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic sweep(input int px, input int py);
        pacman_left_x = 10'(px);
        pacman_top_y  = 9'(py);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (N) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        rom_x = '{100, 200, 300, 400};
        rom_y = '{50, 50, 80, 80};
        rom_k = '{1, 1, 0, 2};
        reset = 1'b1; frame_start = 1'b0; level_restart = 1'b0;
        pacman_left_x = '0; pacman_top_y = '0; draw_idx = '0;
        tick(); tick();
        check("reset_busy", busy, 1);
        check("reset_rom_addr", rom_addr, 0);
        reset = 1'b0;
        repeat (8) tick();
        check("load_vis", coin_vis, 4'b1011);
        check("load_busy", busy, 0);
        draw_idx = 3'd1; #1;
        check("draw1_x", draw_x, 200);
        check("draw1_y", draw_y, 50);
        check("draw1_vis", draw_vis, 1);
        draw_idx = 3'd5; #1;
        check("draw5_x", draw_x, 0);

        sweep(110, 66);
        check("ymiss_vis", coin_vis, 4'b1011);
        e0 = eaten_cnt;
        sweep(110, 65);
        check("yhit_vis", coin_vis, 4'b1010);
        check("yhit_score", score, 1);
        check("yhit_eaten_pulses", eaten_cnt - e0, 1);
        sweep(190, 65);
        check("hit1_vis", coin_vis, 4'b1000);
        sweep(416, 80);
        check("xmiss_vis", coin_vis, 4'b1000);
        sweep(375, 80);
        check("xhit_vis", coin_vis, 4'b0000);
        check("xhit_score", score, 3);
        check("all_collected_set", all_collected, 1);

        pacman_left_x = '0; pacman_top_y = '0;
        level_restart = 1'b1; tick(); level_restart = 1'b0;
        check("restart_all_collected", all_collected, 0);
        check("restart_score", score, 0);
        tick();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        tick();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        repeat (4) tick();
        check("reload_vis", coin_vis, 4'b1011);
        check("reload_busy", busy, 0);
        tick();
        check("pending_sweep_busy", busy, 1);
        repeat (4) tick();
        check("pending_sweep_done", busy, 0);
        repeat (6) tick();
        check("second_pulse_dropped", busy, 0);

        rom_x[2] = 1010; rom_y[2] = 500; rom_k[2] = 3;
        level_restart = 1'b1; tick(); level_restart = 1'b0;
        repeat (8) tick();
        check("edge_load_vis", coin_vis, 4'b1111);
        draw_idx = 3'd2; #1;
        check("draw2_x", draw_x, 1010);
        check("draw2_y", draw_y, 500);
        sweep(1020, 500);
        check("edge_hit_vis", coin_vis, 4'b1011);
        check("edge_hit_score", score, 1);

        pacman_left_x = 10'd90; pacman_top_y = 9'd40;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        tick(); tick();
        reset = 1'b1; tick();
        check("midreset_vis", coin_vis, 0);
        check("midreset_score", score, 0);
        check("midreset_busy", busy, 1);
        check("midreset_rom_addr", rom_addr, 0);
        check("midreset_eaten", eaten, 0);
        check("midreset_draw_x", draw_x, 0);
        reset = 1'b0;
        repeat (8) tick();
        check("postreset_vis", coin_vis, 4'b1111);
        check("postreset_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
